// File: rtl/pair_dist_gen_pkg.sv
// Shared types for the pair-distance producer and the sort chain it feeds.
// conn_t is the record format consumed at the head of the sort chain.
package pair_dist_gen_pkg;

  localparam int DEF_NUM_POINTS = 1000;
  localparam int DEF_DIM_W      = 17;
  localparam int PT_IDX_W       = $clog2(DEF_NUM_POINTS);
  localparam int DIST_W         = 2 * DEF_DIM_W + 2;

  typedef struct packed {
    logic [DEF_DIM_W-1:0] x;
    logic [DEF_DIM_W-1:0] y;
    logic [DEF_DIM_W-1:0] z;
  } point_t;

  typedef struct packed {
    logic [DIST_W-1:0]   distance;
    logic [PT_IDX_W-1:0] pointa;
    logic [PT_IDX_W-1:0] pointb;
  } conn_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH,
    READ
  } state_t;

  // Square of a signed difference; the magnitude never exceeds 2^DIM_W-1,
  // so the unsigned product fits exactly in 2*DIM_W bits.
  function automatic logic [2*DEF_DIM_W-1:0] square_diff(input logic signed [DEF_DIM_W:0] d);
    logic [DEF_DIM_W-1:0]   mag;
    logic [2*DEF_DIM_W-1:0] ext;
    mag = d[DEF_DIM_W] ? DEF_DIM_W'(-d) : d[DEF_DIM_W-1:0];
    ext = {{DEF_DIM_W{1'b0}}, mag};
    return ext * ext;
  endfunction

endpackage

// File: rtl/pair_dist_gen_sq_dist_pipe.sv
// Squared-distance datapath: difference, square and sum stages, carrying
// a valid bit and the pair indices alongside the data.
module sq_dist_pipe
  import pair_dist_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  point_t              in_a,
  input  point_t              in_b,
  input  logic [PT_IDX_W-1:0] in_idx_a,
  input  logic [PT_IDX_W-1:0] in_idx_b,
  output conn_t               conn_out,
  output logic                conn_out_vld,
  output logic                pending
);

  logic [3*DEF_DIM_W-1:0] a_vec;
  logic [3*DEF_DIM_W-1:0] b_vec;
  logic                   s2_vld_reg;
  logic                   s3_vld_reg;
  logic [PT_IDX_W-1:0]    s2_ia_reg, s2_ib_reg;
  logic [PT_IDX_W-1:0]    s3_ia_reg, s3_ib_reg;
  logic [DIST_W-1:0]      dist_next;

  assign a_vec = in_a;
  assign b_vec = in_b;

  // Axis 0 is x (MSBs), axis 2 is z.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [DEF_DIM_W:0]   diff_reg;
      logic        [2*DEF_DIM_W-1:0] sq_reg;

      always_ff @(posedge clk) begin
        diff_reg <= {1'b0, a_vec[(2-gi)*DEF_DIM_W +: DEF_DIM_W]}
                  - {1'b0, b_vec[(2-gi)*DEF_DIM_W +: DEF_DIM_W]};
        sq_reg   <= square_diff(diff_reg);
      end
    end
  endgenerate

  assign dist_next = DIST_W'(g_axis[0].sq_reg)
                   + DIST_W'(g_axis[1].sq_reg)
                   + DIST_W'(g_axis[2].sq_reg);

  always_ff @(posedge clk) begin
    s2_ia_reg <= in_idx_a;
    s2_ib_reg <= in_idx_b;
    s3_ia_reg <= s2_ia_reg;
    s3_ib_reg <= s2_ib_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_reg   <= 1'b0;
      s3_vld_reg   <= 1'b0;
      conn_out_vld <= 1'b0;
      conn_out     <= '0;
    end else begin
      s2_vld_reg   <= in_vld;
      s3_vld_reg   <= s2_vld_reg;
      conn_out_vld <= s3_vld_reg;
      if (s3_vld_reg) begin
        conn_out.distance <= dist_next;
        conn_out.pointa   <= s3_ia_reg;
        conn_out.pointb   <= s3_ib_reg;
      end
    end
  end

  assign pending = s2_vld_reg | s3_vld_reg;

endmodule

// File: rtl/pair_dist_gen.sv
// Walks all unordered point pairs (i<j) of the loaded table and streams their
// squared distances into the sort chain, then pulses sort_read.
module pair_dist_gen
  import pair_dist_gen_pkg::*;
#(
  parameter int NUM_POINTS = DEF_NUM_POINTS,
  parameter int DIM_W      = DEF_DIM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pt_wr_en,
  input  logic [PT_IDX_W-1:0] pt_wr_addr,
  input  logic [3*DIM_W-1:0]  pt_wr_data,
  input  logic [PT_IDX_W:0]   num_pts,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output conn_t               conn_out,
  output logic                conn_out_vld,
  output logic                sort_read
);

  localparam logic [PT_IDX_W:0]   NUM_MAX = (PT_IDX_W+1)'(NUM_POINTS);
  localparam logic [PT_IDX_W:0]   ONE_W   = (PT_IDX_W+1)'(1);
  localparam logic [PT_IDX_W:0]   TWO_W   = (PT_IDX_W+1)'(2);
  localparam logic [PT_IDX_W-1:0] ONE_I   = PT_IDX_W'(1);
  localparam logic [PT_IDX_W-1:0] TWO_I   = PT_IDX_W'(2);

  state_t              state;
  logic [PT_IDX_W:0]   num_reg;
  logic [PT_IDX_W-1:0] i_reg, j_reg;
  logic                issue;
  logic                j_last, i_last;
  logic                wr_ok;
  logic                pipe_pending;

  point_t              pt_mem [NUM_POINTS];
  point_t              rd_a_reg, rd_b_reg;
  logic                s1_vld_reg;
  logic [PT_IDX_W-1:0] s1_ia_reg, s1_ib_reg;

  assign issue  = (state == ISSUE) && (num_reg >= TWO_W);
  assign j_last = ({1'b0, j_reg} == num_reg - ONE_W);
  assign i_last = ({1'b0, i_reg} == num_reg - TWO_W);
  assign wr_ok  = pt_wr_en && (state == IDLE) && ({1'b0, pt_wr_addr} < NUM_MAX);

  // Table is never reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) pt_mem[pt_wr_addr] <= pt_wr_data;
    rd_a_reg  <= pt_mem[i_reg];
    rd_b_reg  <= pt_mem[j_reg];
    s1_ia_reg <= i_reg;
    s1_ib_reg <= j_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) s1_vld_reg <= 1'b0;
    else        s1_vld_reg <= issue;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sort_read <= 1'b0;
      num_reg   <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      done      <= 1'b0;
      sort_read <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ISSUE;
            busy    <= 1'b1;
            num_reg <= (num_pts > NUM_MAX) ? NUM_MAX : num_pts;
            i_reg   <= '0;
            j_reg   <= ONE_I;
          end
        end
        ISSUE: begin
          if (num_reg < TWO_W) begin
            state <= FLUSH;
          end else if (j_last) begin
            if (i_last) begin
              state <= FLUSH;
            end else begin
              i_reg <= i_reg + ONE_I;
              j_reg <= i_reg + TWO_I;
            end
          end else begin
            j_reg <= j_reg + ONE_I;
          end
        end
        // The final pair is in the output register when S1..S3 are empty,
        // so sort_read lands exactly one cycle after the last valid.
        FLUSH: begin
          if (!s1_vld_reg && !pipe_pending) begin
            state     <= READ;
            done      <= 1'b1;
            sort_read <= 1'b1;
          end
        end
        READ: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sq_dist_pipe u_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_vld       (s1_vld_reg),
    .in_a         (rd_a_reg),
    .in_b         (rd_b_reg),
    .in_idx_a     (s1_ia_reg),
    .in_idx_b     (s1_ib_reg),
    .conn_out     (conn_out),
    .conn_out_vld (conn_out_vld),
    .pending      (pipe_pending)
  );

endmodule

// File: tb/tb_pair_dist_gen.sv
// Directed bench for pair_dist_gen: ordering, latency, edge counts,
// arithmetic extremes, ignored requests while busy and mid-run reset.
module tb_pair_dist_gen;
  import pair_dist_gen_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  pt_wr_en;
  logic [PT_IDX_W-1:0]   pt_wr_addr;
  logic [3*DEF_DIM_W-1:0] pt_wr_data;
  logic [PT_IDX_W:0]     num_pts;
  logic                  start;
  logic                  busy;
  logic                  done;
  conn_t                 conn_out;
  logic                  conn_out_vld;
  logic                  sort_read;

  always #5 clk = ~clk;

  pair_dist_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pt_wr_en     (pt_wr_en),
    .pt_wr_addr   (pt_wr_addr),
    .pt_wr_data   (pt_wr_data),
    .num_pts      (num_pts),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .conn_out     (conn_out),
    .conn_out_vld (conn_out_vld),
    .sort_read    (sort_read)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  conn_t got_q[$];
  int    first_vld, last_vld, sr_cycle, sr_count, done_count, overlap;
  longint mx[16], my[16], mz[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_pt(input int idx, input int x, input int y, input int z);
    @(negedge clk);
    pt_wr_en   = 1'b1;
    pt_wr_addr = idx[PT_IDX_W-1:0];
    pt_wr_data = {x[DEF_DIM_W-1:0], y[DEF_DIM_W-1:0], z[DEF_DIM_W-1:0]};
    mx[idx] = longint'(x);
    my[idx] = longint'(y);
    mz[idx] = longint'(z);
    @(negedge clk);
    pt_wr_en = 1'b0;
  endtask

  function automatic longint mdist(input int a, input int b);
    longint dx, dy, dz;
    dx = mx[a] - mx[b];
    dy = my[a] - my[b];
    dz = mz[a] - mz[b];
    return dx*dx + dy*dy + dz*dz;
  endfunction

  // mode 0: plain run; 1: start + table write injected at cycle 'at';
  // 2: reset asserted at cycle 'at'. Cycle 1 is the cycle after start is taken.
  task automatic run(input int n, input int mode, input int at);
    got_q.delete();
    first_vld = -1; last_vld = -1; sr_cycle = -1;
    sr_count = 0; done_count = 0; overlap = 0;
    @(negedge clk);
    start   = 1'b1;
    num_pts = n[PT_IDX_W:0];
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      if (k == 1) check("busy_rise", busy, 1);
      if (conn_out_vld) begin
        if (first_vld < 0) first_vld = k;
        last_vld = k;
        got_q.push_back(conn_out);
        $display("conn cyc=%0d a=%0d b=%0d dist=%0d", k, conn_out.pointa, conn_out.pointb, conn_out.distance);
      end
      if (sort_read) begin
        sr_count++;
        sr_cycle = k;
      end
      if (done) done_count++;
      if (sort_read && conn_out_vld) overlap++;
      if (sr_cycle > 0 && k == sr_cycle + 1) begin
        check("busy_after_read", busy, 0);
        $display("run n=%0d: pairs=%0d first=%0d last=%0d sort_read=%0d", n, got_q.size(), first_vld, last_vld, sr_cycle);
        return;
      end
      if (mode == 2 && k == at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_vld", conn_out_vld, 0);
        check("rst_sort_read", sort_read, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        $display("run n=%0d: reset at cycle %0d", n, at);
        return;
      end
      if (mode == 1 && k == at) begin
        start      = 1'b1;
        pt_wr_en   = 1'b1;
        pt_wr_addr = PT_IDX_W'(3);
        pt_wr_data = '1;
      end else begin
        start    = 1'b0;
        pt_wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check("run_timeout", 0, 1);
  endtask

  task automatic check_against_model(input int n, input string tag);
    int    idx;
    conn_t e;
    check({tag, "_npairs"}, got_q.size(), n*(n-1)/2);
    check({tag, "_first_vld"}, first_vld, 5);
    check({tag, "_sr_after_last"}, sr_cycle, last_vld + 1);
    check({tag, "_contiguous"}, last_vld - first_vld + 1, n*(n-1)/2);
    check({tag, "_overlap"}, overlap, 0);
    idx = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        e.distance = DIST_W'(mdist(i, j));
        e.pointa   = PT_IDX_W'(i);
        e.pointb   = PT_IDX_W'(j);
        if (idx < got_q.size())
          check($sformatf("%s_pair_%0d_%0d", tag, i, j), got_q[idx], e);
        idx++;
      end
    end
  endtask

  initial begin
    int extra;
    rst_n = 1'b0; pt_wr_en = 1'b0; pt_wr_addr = '0; pt_wr_data = '0;
    num_pts = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_vld", conn_out_vld, 0);
    check("reset_sort_read", sort_read, 0);
    check("reset_conn_out", conn_out, 0);
    rst_n = 1'b1;

    // Three-point example.
    write_pt(0, 0, 0, 0);
    write_pt(1, 1, 2, 2);
    write_pt(2, 3, 0, 4);
    run(3, 0, 0);
    check("t3_npairs", got_q.size(), 3);
    check("t3_d01", got_q[0].distance, 9);
    check("t3_a01", got_q[0].pointa, 0);
    check("t3_b01", got_q[0].pointb, 1);
    check("t3_d02", got_q[1].distance, 25);
    check("t3_a02", got_q[1].pointa, 0);
    check("t3_b02", got_q[1].pointb, 2);
    check("t3_d12", got_q[2].distance, 12);
    check("t3_a12", got_q[2].pointa, 1);
    check("t3_b12", got_q[2].pointb, 2);
    check("t3_first_vld", first_vld, 5);
    check("t3_last_vld", last_vld, 7);
    check("t3_sort_read_cyc", sr_cycle, 8);
    check("t3_sort_read_cnt", sr_count, 1);
    check("t3_done_cnt", done_count, 1);
    check("t3_overlap", overlap, 0);
    check("t3_hold", conn_out, got_q[2]);

    // Degenerate counts: nothing issued, single read pulse.
    run(1, 0, 0);
    check("n1_npairs", got_q.size(), 0);
    check("n1_sort_read_cnt", sr_count, 1);
    check("n1_done_cnt", done_count, 1);
    check("n1_sort_read_cyc", sr_cycle, 3);
    run(0, 0, 0);
    check("n0_npairs", got_q.size(), 0);
    check("n0_sort_read_cnt", sr_count, 1);
    check("n0_done_cnt", done_count, 1);
    check("n0_sort_read_cyc", sr_cycle, 3);

    // Full-scale coordinates: 3*(2^17-1)^2.
    write_pt(0, 0, 0, 0);
    write_pt(1, 131071, 131071, 131071);
    run(2, 0, 0);
    check("max_npairs", got_q.size(), 1);
    check("max_dist", got_q[0].distance, 64'd51538821123);

    // Mixed-sign differences: dx=+3, dy=-4, dz=0.
    write_pt(0, 5, 5, 5);
    write_pt(1, 2, 9, 5);
    run(2, 0, 0);
    check("sign_npairs", got_q.size(), 1);
    check("sign_dist", got_q[0].distance, 25);

    // Ten-point table; start and table write during ISSUE must be ignored.
    for (int p = 0; p < 10; p++)
      write_pt(p, p * 13001 + 7, (9 - p) * 12345, (p * p * 1613) % 131072);
    run(10, 1, 3);
    check_against_model(10, "disturb");
    check("disturb_sort_read_cnt", sr_count, 1);
    run(10, 0, 0);
    check_against_model(10, "rerun");

    // Reset mid-ISSUE, then a clean rerun from the retained table.
    run(10, 2, 4);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (sort_read || done || conn_out_vld || busy) extra++;
    end
    check("post_reset_quiet", extra, 0);
    run(10, 0, 0);
    check_against_model(10, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
